// File: rtl/control_sequencer.sv
// control_sequencer
//
// Microcoded-style T-state sequencer for a simple 8-bit accumulator machine.
// Walks the fetch cycle (T1..T3) and the execute cycles (T4..T6) of each
// instruction and decodes the bus/load enables combinationally from the
// current T-state and the instruction opcode.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_T1     | address: PC drives bus, MAR loads
//   S_T2     | increment: PC advances
//   S_T3     | fetch: RAM drives bus, IR loads
//   S_T4     | execute 1: operand address (LDA/ADD/SUB), OUT transfer, HLT/NOP
//   S_T5     | execute 2: RAM operand into A (LDA) or B (ADD/SUB)
//   S_T6     | execute 3: ALU result into A (ADD/SUB)
//   S_HALTED | machine stopped until RESET
//
// Ports
//   CLOCK        in   system clock, rising edge active
//   RESET        in   asynchronous active-high reset, forces T1
//   OPCODE[3:0]  in   instruction register upper nibble, valid from T4
//   PC_INC       out  program counter increment (active high)
//   _EN_*        out  bus-driver and register-load enables (active low)
//   SUB          out  ALU subtract select (active high)
//   HALT         out  machine halted (active high)
//   T_STATE[5:0] out  one-hot T-state, bit0 = T1; zero when halted

module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] OPCODE,
    output logic       PC_INC,
    output logic       _EN_PC_OUT,
    output logic       _EN_MAR_IN,
    output logic       _EN_RAM_OUT,
    output logic       _EN_IR_IN,
    output logic       _EN_IR_OUT,
    output logic       _EN_A_IN,
    output logic       _EN_A_OUT,
    output logic       _EN_B_IN,
    output logic       _EN_ALU_OUT,
    output logic       _EN_OUT_IN,
    output logic       SUB,
    output logic       HALT,
    output logic [5:0] T_STATE
);

    typedef enum logic [2:0] {
        S_T1     = 3'd0,
        S_T2     = 3'd1,
        S_T3     = 3'd2,
        S_T4     = 3'd3,
        S_T5     = 3'd4,
        S_T6     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;

    assign is_lda = (OPCODE == OP_LDA);
    assign is_add = (OPCODE == OP_ADD);
    assign is_sub = (OPCODE == OP_SUB);
    assign is_out = (OPCODE == OP_OUT);
    assign is_hlt = (OPCODE == OP_HLT);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= S_T1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = S_T1;
        PC_INC      = 1'b0;
        _EN_PC_OUT  = 1'b1;
        _EN_MAR_IN  = 1'b1;
        _EN_RAM_OUT = 1'b1;
        _EN_IR_IN   = 1'b1;
        _EN_IR_OUT  = 1'b1;
        _EN_A_IN    = 1'b1;
        _EN_A_OUT   = 1'b1;
        _EN_B_IN    = 1'b1;
        _EN_ALU_OUT = 1'b1;
        _EN_OUT_IN  = 1'b1;
        SUB         = 1'b0;
        HALT        = 1'b0;
        T_STATE     = 6'b000000;

        case (state)
            S_T1: begin
                T_STATE    = 6'b000001;
                _EN_PC_OUT = 1'b0;
                _EN_MAR_IN = 1'b0;
                state_next = S_T2;
            end
            S_T2: begin
                T_STATE    = 6'b000010;
                PC_INC     = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                T_STATE     = 6'b000100;
                _EN_RAM_OUT = 1'b0;
                _EN_IR_IN   = 1'b0;
                state_next  = S_T4;
            end
            S_T4: begin
                T_STATE = 6'b001000;
                if (is_lda || is_add || is_sub) begin
                    _EN_IR_OUT = 1'b0;
                    _EN_MAR_IN = 1'b0;
                    state_next = S_T5;
                end else if (is_out) begin
                    _EN_A_OUT  = 1'b0;
                    _EN_OUT_IN = 1'b0;
                    state_next = S_T1;
                end else if (is_hlt) begin
                    state_next = S_HALTED;
                end else begin
                    state_next = S_T1;
                end
            end
            S_T5: begin
                T_STATE = 6'b010000;
                // An opcode that changed mid-instruction falls back to T1
                // with nothing enabled rather than finishing a half-decoded op.
                if (is_lda) begin
                    _EN_RAM_OUT = 1'b0;
                    _EN_A_IN    = 1'b0;
                    state_next  = S_T1;
                end else if (is_add || is_sub) begin
                    _EN_RAM_OUT = 1'b0;
                    _EN_B_IN    = 1'b0;
                    state_next  = S_T6;
                end else begin
                    state_next = S_T1;
                end
            end
            S_T6: begin
                T_STATE = 6'b100000;
                if (is_add || is_sub) begin
                    _EN_ALU_OUT = 1'b0;
                    _EN_A_IN    = 1'b0;
                    SUB         = is_sub;
                end
                state_next = S_T1;
            end
            S_HALTED: begin
                HALT       = 1'b1;
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_T1;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Directed bench for control_sequencer. A table of per-cycle records
// {reset, opcode, expected T-state/enables/PC_INC/SUB/HALT} is applied one
// record per clock, sampled half a cycle away from the rising edge. Hand
// sequences then cover the long halt, asynchronous reset out of HALTED and
// a reset landing in T5 of an ADD.

module tb_control_sequencer;

    logic       CLOCK;
    logic       RESET;
    logic [3:0] OPCODE;
    logic       PC_INC;
    logic       _EN_PC_OUT;
    logic       _EN_MAR_IN;
    logic       _EN_RAM_OUT;
    logic       _EN_IR_IN;
    logic       _EN_IR_OUT;
    logic       _EN_A_IN;
    logic       _EN_A_OUT;
    logic       _EN_B_IN;
    logic       _EN_ALU_OUT;
    logic       _EN_OUT_IN;
    logic       SUB;
    logic       HALT;
    logic [5:0] T_STATE;

    control_sequencer dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .OPCODE      (OPCODE),
        .PC_INC      (PC_INC),
        ._EN_PC_OUT  (_EN_PC_OUT),
        ._EN_MAR_IN  (_EN_MAR_IN),
        ._EN_RAM_OUT (_EN_RAM_OUT),
        ._EN_IR_IN   (_EN_IR_IN),
        ._EN_IR_OUT  (_EN_IR_OUT),
        ._EN_A_IN    (_EN_A_IN),
        ._EN_A_OUT   (_EN_A_OUT),
        ._EN_B_IN    (_EN_B_IN),
        ._EN_ALU_OUT (_EN_ALU_OUT),
        ._EN_OUT_IN  (_EN_OUT_IN),
        .SUB         (SUB),
        .HALT        (HALT),
        .T_STATE     (T_STATE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Enable vector order, bit9..bit0:
    // pc_out, mar_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, alu_out, out_in
    localparam logic [9:0] EN_NONE = 10'b11_1111_1111;
    localparam logic [9:0] EN_T1   = 10'b00_1111_1111;
    localparam logic [9:0] EN_T3   = 10'b11_0011_1111;
    localparam logic [9:0] EN_ADDR = 10'b10_1101_1111;
    localparam logic [9:0] EN_LDA5 = 10'b11_0110_1111;
    localparam logic [9:0] EN_B5   = 10'b11_0111_1011;
    localparam logic [9:0] EN_ALU6 = 10'b11_1110_1101;
    localparam logic [9:0] EN_OUT4 = 10'b11_1111_0110;

    typedef struct {
        logic       rst;
        logic [3:0] op;
        logic [5:0] t;
        logic [9:0] en;
        logic       pc;
        logic       sub;
        logic       halt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [9:0] en_now();
        return {_EN_PC_OUT, _EN_MAR_IN, _EN_RAM_OUT, _EN_IR_IN, _EN_IR_OUT,
                _EN_A_IN, _EN_A_OUT, _EN_B_IN, _EN_ALU_OUT, _EN_OUT_IN};
    endfunction

    task automatic add_vec(input logic rst, input logic [3:0] op, input logic [5:0] t,
                           input logic [9:0] en, input logic pc, input logic sub,
                           input logic halt);
        vec_t v;
        v.rst = rst; v.op = op; v.t = t; v.en = en; v.pc = pc; v.sub = sub; v.halt = halt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [5:0] t, input logic [9:0] en,
                         input logic pc, input logic sub, input logic halt);
        logic [18:0] act;
        logic [18:0] exp;
        logic [4:0]  drv;
        act = {T_STATE, en_now(), PC_INC, SUB, HALT};
        exp = {t, en, pc, sub, halt};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got t=%h en=%b pc_inc=%b sub=%b halt=%b, want t=%h en=%b pc_inc=%b sub=%b halt=%b",
                     name, T_STATE, en_now(), PC_INC, SUB, HALT, t, en, pc, sub, halt);
        end
        drv = {_EN_PC_OUT, _EN_RAM_OUT, _EN_IR_OUT, _EN_A_OUT, _EN_ALU_OUT};
        n_checks++;
        if ($countones(~drv) > 1) begin
            n_fail++;
            $display("FAIL %s bus_drivers: got drivers=%b, want at most one zero", name, drv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t, want completion before it", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET  = 1'b1;
        OPCODE = 4'h0;

        // reset held, then released: LDA loop
        add_vec(1, 4'h0, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h0, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h0, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h0, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h0, 6'h08, EN_ADDR, 0, 0, 0);
        add_vec(0, 4'h0, 6'h10, EN_LDA5, 0, 0, 0);
        // SUB: six cycles
        add_vec(0, 4'h2, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h2, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h2, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h2, 6'h08, EN_ADDR, 0, 0, 0);
        add_vec(0, 4'h2, 6'h10, EN_B5,   0, 0, 0);
        add_vec(0, 4'h2, 6'h20, EN_ALU6, 0, 1, 0);
        // OUT: four cycles
        add_vec(0, 4'hE, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'hE, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'hE, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'hE, 6'h08, EN_OUT4, 0, 0, 0);
        // ADD: six cycles, SUB stays low
        add_vec(0, 4'h1, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h1, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h1, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h1, 6'h08, EN_ADDR, 0, 0, 0);
        add_vec(0, 4'h1, 6'h10, EN_B5,   0, 0, 0);
        add_vec(0, 4'h1, 6'h20, EN_ALU6, 0, 0, 0);
        // NOP opcode 7: four cycles
        add_vec(0, 4'h7, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h7, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h7, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h7, 6'h08, EN_NONE, 0, 0, 0);
        // LDA whose opcode changes to OUT in T5
        add_vec(0, 4'h0, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h0, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h0, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h0, 6'h08, EN_ADDR, 0, 0, 0);
        add_vec(0, 4'hE, 6'h10, EN_NONE, 0, 0, 0);
        // SUB whose opcode changes to LDA in T6
        add_vec(0, 4'h2, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'h2, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'h2, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'h2, 6'h08, EN_ADDR, 0, 0, 0);
        add_vec(0, 4'h2, 6'h10, EN_B5,   0, 0, 0);
        add_vec(0, 4'h0, 6'h20, EN_NONE, 0, 0, 0);
        // HLT
        add_vec(0, 4'hF, 6'h01, EN_T1,   0, 0, 0);
        add_vec(0, 4'hF, 6'h02, EN_NONE, 1, 0, 0);
        add_vec(0, 4'hF, 6'h04, EN_T3,   0, 0, 0);
        add_vec(0, 4'hF, 6'h08, EN_NONE, 0, 0, 0);
        add_vec(0, 4'hF, 6'h00, EN_NONE, 0, 0, 1);

        foreach (vecs[i]) begin
            @(negedge CLOCK);
            RESET  = vecs[i].rst;
            OPCODE = vecs[i].op;
            #1;
            check($sformatf("vec%0d", i), vecs[i].t, vecs[i].en, vecs[i].pc,
                  vecs[i].sub, vecs[i].halt);
        end

        // stays halted with opcodes that would otherwise execute
        for (int k = 0; k < 22; k++) begin
            @(negedge CLOCK);
            OPCODE = 4'(k);
            #1;
            check("halted_hold", 6'h00, EN_NONE, 0, 0, 1);
        end

        // asynchronous reset out of HALTED, well before the next rising edge
        #1;
        RESET = 1'b1;
        #1;
        check("halt_async_rst", 6'h01, EN_T1, 0, 0, 0);
        @(negedge CLOCK);
        OPCODE = 4'h1;
        #1;
        check("rst_hold", 6'h01, EN_T1, 0, 0, 0);
        RESET = 1'b0;
        @(negedge CLOCK);
        #1;
        check("rst_release_t2", 6'h02, EN_NONE, 1, 0, 0);
        @(negedge CLOCK);
        #1;
        check("add_t3", 6'h04, EN_T3, 0, 0, 0);
        @(negedge CLOCK);
        #1;
        check("add_t4", 6'h08, EN_ADDR, 0, 0, 0);
        @(negedge CLOCK);
        #1;
        check("add_t5", 6'h10, EN_B5, 0, 0, 0);

        // reset lands in T5 of the ADD: back to T1 at once, A never loads
        #1;
        RESET = 1'b1;
        #1;
        check("mid_t5_rst", 6'h01, EN_T1, 0, 0, 0);
        @(negedge CLOCK);
        #1;
        check("mid_t5_rst_hold", 6'h01, EN_T1, 0, 0, 0);
        RESET = 1'b0;
        @(negedge CLOCK);
        #1;
        check("mid_t5_release_t2", 6'h02, EN_NONE, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // _EN_A_IN must not pulse while RESET is held
    always @(negedge CLOCK) begin
        if (RESET && !_EN_A_IN) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_in_under_reset: got _EN_A_IN=%b, want 1", _EN_A_IN);
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OP_LDA, default 4'h0, load A from RAM[operand].
REQ-002 SHALL have parameter OP_ADD, default 4'h1, A <= A + RAM[operand].
REQ-003 SHALL have parameter OP_SUB, default 4'h2, A <= A - RAM[operand].
REQ-004 SHALL have parameter OP_OUT, default 4'hE, output register <= A.
REQ-005 SHALL have parameter OP_HLT, default 4'hF, stop sequencing.
REQ-006 SHALL have port CLOCK  input  1  single system clock; all state changes on rising edge.
REQ-007 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port OPCODE  input  4  instruction-register upper nibble (IR_OUT[7:4]).
REQ-009 SHALL have port PC_INC  output  1  active-high program-counter increment.
REQ-010 SHALL have ports _EN_PC_OUT, _EN_MAR_IN, _EN_RAM_OUT, _EN_IR_IN, _EN_IR_OUT, _EN_A_IN, _EN_A_OUT, _EN_B_IN, _EN_ALU_OUT, _EN_OUT_IN  output  1 each  active-low bus/load enables.
REQ-011 SHALL have port SUB  output  1  active-high ALU subtract select.
REQ-012 SHALL have port HALT  output  1  active-high, machine halted.
REQ-013 SHALL have port T_STATE  output  6  one-hot current T-state (bit0 = T1 ... bit5 = T6); 6'b000000 when halted.

Function
REQ-014 SHALL implement states T1..T6 plus HALTED in a registered state machine; all control outputs decoded combinationally from state and OPCODE.
REQ-015 Default, every state: all active-low enables = 1, PC_INC = 0, SUB = 0, HALT = 0.
REQ-016 T1 (address): _EN_PC_OUT = 0, _EN_MAR_IN = 0; next T2.
REQ-017 T2 (increment): PC_INC = 1; next T3.
REQ-018 T3 (fetch): _EN_RAM_OUT = 0, _EN_IR_IN = 0; next T4; OPCODE is valid from T4 onward.
REQ-019 T4, OPCODE in {LDA, ADD, SUB}: _EN_IR_OUT = 0, _EN_MAR_IN = 0; next T5.
REQ-020 T4, OPCODE = OUT: _EN_A_OUT = 0, _EN_OUT_IN = 0; next T1.
REQ-021 T4, OPCODE = HLT: no enables asserted; next HALTED.
REQ-022 T4, any other OPCODE: no enables asserted (NOP); next T1.
REQ-023 T5, LDA: _EN_RAM_OUT = 0, _EN_A_IN = 0; next T1.
REQ-024 T5, ADD/SUB: _EN_RAM_OUT = 0, _EN_B_IN = 0; next T6.
REQ-025 T6, ADD: _EN_ALU_OUT = 0, _EN_A_IN = 0, SUB = 0; next T1.
REQ-026 T6, SUB: _EN_ALU_OUT = 0, _EN_A_IN = 0, SUB = 1; next T1.
REQ-027 T5/T6 with an OPCODE not listed for that state (OPCODE changed mid-instruction): no enables; next T1.
REQ-028 HALTED: HALT = 1, all enables inactive, PC_INC = 0; remains HALTED until RESET.
REQ-029 At most one driver enable (_EN_*_OUT, _EN_RAM_OUT) SHALL be low in any state.
REQ-030 Instruction length SHALL be: LDA 5, ADD/SUB 6, OUT 4, NOP 4 cycles; HLT reaches HALTED after 4 cycles.

Reset
REQ-031 RESET high SHALL immediately, without waiting for a clock edge, force state to T1.
REQ-032 While RESET is high, state SHALL stay T1 and T_STATE = 6'b000001; the T1 enables follow REQ-016.
REQ-033 RESET asserted in any state, including HALTED or mid-instruction, SHALL abort that instruction; the first rising edge after RESET falls SHALL advance to T2.

Verification
REQ-034 Reset release, OPCODE = 4'h0: T_STATE sequence 01,02,04,08,10,01 (hex); T4 _EN_IR_OUT = _EN_MAR_IN = 0; T5 _EN_RAM_OUT = _EN_A_IN = 0.
REQ-035 OPCODE = 4'h2: six-cycle loop; SUB = 1 only in T6 together with _EN_ALU_OUT = _EN_A_IN = 0; _EN_B_IN = 0 in T5.
REQ-036 OPCODE = 4'hE: four-cycle loop; T4 _EN_A_OUT = _EN_OUT_IN = 0; next cycle T_STATE = 6'h01.
REQ-037 OPCODE = 4'hF: after T4, HALT = 1 and T_STATE = 0 for 20+ cycles; pulse RESET -> T_STATE = 6'h01 asynchronously, HALT = 0.
REQ-038 OPCODE = 4'h7: T4 all enables high; then T1. Assert RESET mid-T5 of an ADD -> T1 at once, no _EN_A_IN pulse.
REQ-039 Every cycle of every test: driver enables (_EN_PC_OUT, _EN_RAM_OUT, _EN_IR_OUT, _EN_A_OUT, _EN_ALU_OUT) contain at most one zero.
